// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline freeze/flush controller:
// sequencer state encoding, PC register index and default SRAM wait limit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } ctrl_state_t;

    localparam logic [3:0]  REG_PC       = 4'd15;
    localparam int unsigned MAX_WAIT_DEF = 255;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational RAW hazard compare between the ID-stage sources and the
// EXE/MEM destinations. Build option MEM_FWD_EN: with a forwarding unit
// present only the EXE load-use case remains a hazard.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] id_src1,
    input  logic [3:0] id_src2,
    input  logic       id_two_src,
    input  logic       exe_wb_en,
    input  logic       exe_mem_r_en,
    input  logic [3:0] exe_dest,
    input  logic       mem_wb_en,
    input  logic [3:0] mem_dest,
    output logic       hazard
);

    logic src1_live;
    logic src2_live;
    logic exe_hit;

    // PC reads never wait on a writer; src2 only matters when it is read
    always_comb begin
        src1_live = (id_src1 != REG_PC);
        src2_live = id_two_src && (id_src2 != REG_PC);
        exe_hit   = exe_wb_en &&
                    ((src1_live && (exe_dest == id_src1)) ||
                     (src2_live && (exe_dest == id_src2)));
    end

`ifdef MEM_FWD_EN
    logic unused_mem_fwd;
    assign unused_mem_fwd = ^{mem_wb_en, mem_dest};

    // forwarding covers ALU results; only a load in EXE must stall ID
    always_comb begin
        hazard = exe_mem_r_en && exe_hit;
    end
`else
    logic unused_load_flag;
    logic mem_hit;
    assign unused_load_flag = exe_mem_r_en;

    // no forwarding: any pending EXE or MEM write to a source stalls ID
    always_comb begin
        mem_hit = mem_wb_en &&
                  ((src1_live && (mem_dest == id_src1)) ||
                   (src2_live && (mem_dest == id_src2)));
        hazard  = exe_hit || mem_hit;
    end
`endif

endmodule

// File: rtl/pipeline_freeze_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Priority: SRAM wait > taken-branch flush > data-hazard stall.
// Optional macro MEM_FWD_EN selects load-use-only hazard detection.
module pipeline_freeze_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
    parameter int unsigned WAIT_W   = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       exe_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             sram_ready,
    input  logic             branch_taken,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             flush_if,
    output logic             bubble_exe,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    ctrl_state_t       state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              hazard;
    logic              mem_req;

    pipe_hazard_detect u_hazard (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .exe_dest     (exe_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .hazard       (hazard)
    );

    assign mem_req = mem_r_en | mem_w_en;

    // state, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= mem_timeout | (state_nxt == FAULT);
        end
    end

    // next state and same-cycle freeze/flush strobes
    // The detecting RUN cycle counts as the first wait cycle, so WAIT is
    // entered with wait_cnt=1 and MAX_WAIT stalled cycles precede FAULT.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze_if    = 1'b0;
        freeze_id    = 1'b0;
        freeze_exe   = 1'b0;
        freeze_mem   = 1'b0;
        flush_if     = 1'b0;
        bubble_exe   = 1'b0;
        if (rst) begin
            unique case (state)
                RUN: begin
                    wait_cnt_nxt = '0;
                    if (mem_req && !sram_ready) begin
                        {freeze_if, freeze_id, freeze_exe, freeze_mem} = '1;
                        if (MAX_WAIT <= 1) begin
                            state_nxt = FAULT;
                        end else begin
                            state_nxt    = WAIT;
                            wait_cnt_nxt = WAIT_W'(1);
                        end
                    end else if (branch_taken) begin
                        flush_if   = 1'b1;
                        bubble_exe = 1'b1;
                    end else if (hazard) begin
                        freeze_if  = 1'b1;
                        freeze_id  = 1'b1;
                        bubble_exe = 1'b1;
                    end
                end
                WAIT: begin
                    {freeze_if, freeze_id, freeze_exe, freeze_mem} = '1;
                    if (sram_ready) begin
                        state_nxt    = RUN;
                        wait_cnt_nxt = '0;
                    end else if (wait_cnt >= WAIT_LAST) begin
                        state_nxt = FAULT;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end
                FAULT: begin
                    {freeze_if, freeze_id, freeze_exe, freeze_mem} = '1;
                end
                default: begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            endcase
        end
    end

    // saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze_if && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_if && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_freeze_ctrl.sv
// Directed self-checking bench for pipeline_freeze_ctrl (MAX_WAIT=8, CNT_W=4).
// Expectations adapt to the MEM_FWD_EN build option.
module tb_pipeline_freeze_ctrl;

    localparam int unsigned CNT_W = 4;

    // {freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, bubble_exe}
    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] STALL = 6'b110001;
    localparam logic [5:0] FRZ   = 6'b111100;
    localparam logic [5:0] FLSH  = 6'b000011;
`ifdef MEM_FWD_EN
    localparam logic [5:0] ALU_EXP = NONE;
`else
    localparam logic [5:0] ALU_EXP = STALL;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       id_src1, id_src2, exe_dest, mem_dest;
    logic             id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic             mem_r_en, mem_w_en, sram_ready, branch_taken;
    logic             freeze_if, freeze_id, freeze_exe, freeze_mem;
    logic             flush_if, bubble_exe, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;

    pipeline_freeze_ctrl #(.MAX_WAIT(8), .WAIT_W(8), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .exe_dest     (exe_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .sram_ready   (sram_ready),
        .branch_taken (branch_taken),
        .freeze_if    (freeze_if),
        .freeze_id    (freeze_id),
        .freeze_exe   (freeze_exe),
        .freeze_mem   (freeze_mem),
        .flush_if     (flush_if),
        .bubble_exe   (bubble_exe),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dest = 4'd0;
        mem_wb_en = 1'b0; mem_dest = 4'd0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0; branch_taken = 1'b0;
    endtask

    // check strobes for the current cycle, clock once, check registered state
    task automatic step(input string tag, input logic [5:0] e, input logic to_after);
        #1;
        chk({tag, "/strobes"},
            {26'd0, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, bubble_exe},
            {26'd0, e});
        if (rst) begin
            if (e[5] && exp_stall < 15) exp_stall++;
            if (e[1] && exp_flush < 15) exp_flush++;
        end
        @(posedge clk);
        #1;
        chk({tag, "/stall_cnt"}, {28'd0, stall_cnt}, exp_stall);
        chk({tag, "/flush_cnt"}, {28'd0, flush_cnt}, exp_flush);
        chk({tag, "/mem_timeout"}, {31'd0, mem_timeout}, {31'd0, to_after});
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        // reset forces strobes low even with branch and hazard present
        branch_taken = 1'b1;
        exe_wb_en = 1'b1; exe_dest = 4'd2; id_src1 = 4'd2;
        #2;
        step("rst_hold", NONE, 1'b0);
        rst = 1'b1;
        clear_inputs();
        step("idle", NONE, 1'b0);

        // ALU writer in EXE, ID reads it
        exe_wb_en = 1'b1; exe_dest = 4'd2; id_src1 = 4'd2;
        step("alu_exe_raw", ALU_EXP, 1'b0);
        clear_inputs();

        // load to R3 in EXE, ID reads R3: stall in both builds, one cycle
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3;
        step("load_use", STALL, 1'b0);
        clear_inputs();
        step("load_use_gone", NONE, 1'b0);

        // MEM-stage writer matched through src2
        mem_wb_en = 1'b1; mem_dest = 4'd5; id_src2 = 4'd5; id_two_src = 1'b1; id_src1 = 4'd1;
        step("mem_src2_raw", ALU_EXP, 1'b0);
        id_two_src = 1'b0;
        step("src2_not_read", NONE, 1'b0);
        clear_inputs();

        // PC index and inactive write enable never stall
        exe_wb_en = 1'b1; exe_dest = 4'd15; id_src1 = 4'd15;
        step("pc_index", NONE, 1'b0);
        exe_wb_en = 1'b0; exe_dest = 4'd4; id_src1 = 4'd4;
        step("wb_disabled", NONE, 1'b0);
        clear_inputs();

        // branch wins over a simultaneous load-use hazard
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd6; id_src1 = 4'd6;
        branch_taken = 1'b1;
        step("branch_vs_hazard", FLSH, 1'b0);
        clear_inputs();

        // stray sram_ready without a request
        sram_ready = 1'b1;
        step("ready_no_req", NONE, 1'b0);
        clear_inputs();

        // store waits 4 cycles, ready on 5th; branch held throughout
        mem_w_en = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) step("store_wait", FRZ, 1'b0);
        sram_ready = 1'b1;
        step("store_ready", FRZ, 1'b0);
        mem_w_en = 1'b0; sram_ready = 1'b0;
        step("branch_after_wait", FLSH, 1'b0);
        clear_inputs();
        step("back_to_run", NONE, 1'b0);

        // reset in the middle of a wait (wait_cnt=5)
        mem_r_en = 1'b1;
        for (int i = 0; i < 5; i++) step("pre_reset_wait", FRZ, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_async/strobes",
            {26'd0, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, bubble_exe}, 32'd0);
        chk("rst_async/stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst_async/flush_cnt", {28'd0, flush_cnt}, 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("after_reset", NONE, 1'b0);

        // timeout: MAX_WAIT=8, ready never arrives
        mem_r_en = 1'b1;
        for (int i = 0; i < 7; i++) step("timeout_wait", FRZ, 1'b0);
        step("timeout_hit", FRZ, 1'b1);
        mem_r_en = 1'b0; sram_ready = 1'b1;
        // fault holds; stall counter saturates at 15
        for (int i = 0; i < 8; i++) step("fault_hold", FRZ, 1'b1);
        chk("stall_saturated", {28'd0, stall_cnt}, 32'd15);

        // only reset leaves FAULT
        rst = 1'b0;
        #1;
        chk("fault_rst/mem_timeout", {31'd0, mem_timeout}, 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("run_after_fault", NONE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
